regfile_sb: RTL
===============

# regfile_sb

Parametrised multi-port register file with a per-register pending-write scoreboard and a post-reset zeroing sweep. It replaces the fixed 32x32, two-read/one-write register file in the CPU decode stage. It gives the pipeline a second write port for long-latency results (loads, multiply) and exposes busy bits so decode can stall on RAW hazards without extra logic.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers (power of two, ≥4); AW = $clog2(DEPTH)
- NREAD, 2, number of asynchronous read ports (1..4)
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and issue marks

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ra  in  NREAD*AW  read addresses, port k at bits [k*AW +: AW]
- rd  out  NREAD*WIDTH  read data, port k at bits [k*WIDTH +: WIDTH]
- rbusy  out  NREAD  port k address has a pending write
- we0 / wa0 / wd0  in  1 / AW / WIDTH  write port 0 (ALU writeback)
- we1 / wa1 / wd1  in  1 / AW / WIDTH  write port 1 (load/mul writeback); also clears busy
- iss  in  1  issue of a long-latency producer
- iss_addr  in  AW  destination of that producer; sets busy
- ready  out  1  high once the zeroing sweep is finished

## Operation
- The FSM has two states, INIT and RUN. rst forces INIT with the sweep counter at 0.
- INIT: one register is zeroed per cycle, at the counter address. The counter increments each cycle. After address DEPTH-1 is written, the FSM moves to RUN.
- RUN persists until rst is asserted.
- During INIT: we0, we1 and iss are ignored; rd reads 0 on all ports; rbusy reads 0; ready=0.
- RUN writes: on each edge, register wa0 ← wd0 if we0, and register wa1 ← wd1 if we1.
- Same-address conflict: if we0 and we1 target the same address, port 1 wins.
- Scoreboard: iss sets busy[iss_addr]. we1 clears busy[wa1]. we0 does not touch busy.
- If iss and we1 target the same address in the same cycle, the set wins (the new producer supersedes the old one).
- Zero register, when ZERO_REG=1: writes and issues to address 0 are dropped; rd for address 0 = 0; rbusy for address 0 = 0.
- rbusy[k] = busy[ra_k], combinational.
- Reads are combinational from ra. Write-through depends on REGFILE_BYPASS_EN (see Configuration).
- rst in mid-RUN: the FSM restarts INIT and clears every busy bit. Any write or issue in that same cycle is dropped.

## Timing
- Reset values: ready=0, rbusy=0, rd=0. These hold for DEPTH cycles after rst deasserts.
- ready rises on the edge that zeroes register DEPTH-1, which is DEPTH cycles after the last rst cycle.
- Write latency is one edge: data appears at rd in the cycle after we, or in the same cycle with bypass.
- Scoreboard latency is one edge: rbusy rises in the cycle after iss. It falls in the cycle after we1, or in the same cycle with bypass.
- There is no handshake. All inputs are sampled every edge in RUN.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read port whose address matches an active write returns that write's data in the same cycle, with port 1 taking priority.
  - rbusy for an address being written by we1 in that cycle reads 0, unless iss also targets that address in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - Reads return only registered contents.
  - rbusy reflects only the registered busy bit.

## Structure
- The shared package regfile_pkg holds:
  - the FSM state enum (INIT, RUN);
  - default WIDTH/DEPTH localparams;
  - a function computing AW.
- One sub-module, regfile_scoreboard, holds the DEPTH-bit busy vector with its set/clear priority and per-port lookup.
- The storage array, write logic, read muxes, bypass and sweep FSM stay in regfile_sb.

## Test plan
- Reset sweep: pulse rst 1 cycle → ready=0 for exactly 32 cycles, then 1. All 32 registers then read 0 on both ports.
- Zero register: we0=1, wa0=0, wd0=FFFFFFFF; also iss=1, iss_addr=0 → rd for address 0 = 0 and rbusy=0 on the following cycle.
- Dual-write conflict: we0 (r5←11111111) and we1 (r5←22222222) on the same edge → r5 reads 22222222. Also write r1..r31 with DEADBEEF and read back on both ports.
- Write enable: we0=0, wa0=1, wd0=FEEDFEED → r1 still DEADBEEF. Reads are asynchronous: change ra mid-cycle and rd follows within the same half cycle.
- Scoreboard: iss r7 → rbusy=1 next cycle. Then iss r7 together with we1 r7 (wd1=12345678) → r7=12345678 and rbusy stays 1. A following we1 r7 alone → rbusy=0.
- Bypass and reset mid-run:
  - With REGFILE_BYPASS_EN: we0 r9←CAFEF00D with ra=9 → rd=CAFEF00D in the same cycle. Without the macro, rd=old value until the next cycle.
  - rst during RUN with iss pending → all busy bits clear and ready drops for DEPTH cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, defaults and address-width helper for the register file
package regfile_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write busy bits with set-over-clear priority and per-port lookup
// Honours REGFILE_BYPASS_EN: a same-cycle we1 clear is visible on rbusy unless iss re-marks the address.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              iss,
  input  logic [AW-1:0]     iss_addr,
  input  logic              clr,
  input  logic [AW-1:0]     clr_addr,
  input  logic [NREAD*AW-1:0] ra,
  output logic [NREAD-1:0]  rbusy
);

  logic [DEPTH-1:0] busy;
  logic             set_ok;
  logic             clr_ok;

  assign set_ok = run & iss & ~((ZERO_REG != 0) && (iss_addr == '0));
  assign clr_ok = run & clr;

  // The set is applied last so a new producer supersedes the one retiring this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_ok) busy[clr_addr] <= 1'b0;
      if (set_ok) busy[iss_addr] <= 1'b1;
    end
  end

  always_comb begin
    rbusy = '0;
    for (int k = 0; k < NREAD; k++) begin
      rbusy[k] = run & busy[ra[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (clr_ok && (clr_addr == ra[k*AW +: AW]) &&
          !(set_ok && (iss_addr == ra[k*AW +: AW])))
        rbusy[k] = 1'b0;
`endif
      if ((ZERO_REG != 0) && (ra[k*AW +: AW] == '0))
        rbusy[k] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with zeroing sweep and busy scoreboard
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_sb import regfile_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       rbusy,
  input  logic                   we0,
  input  logic [AW-1:0]          wa0,
  input  logic [WIDTH-1:0]       wd0,
  input  logic                   we1,
  input  logic [AW-1:0]          wa1,
  input  logic [WIDTH-1:0]       wd1,
  input  logic                   iss,
  input  logic [AW-1:0]          iss_addr,
  output logic                   ready
);

  state_t           state, state_nx;
  logic [AW-1:0]    cnt, cnt_nx;
  logic             run;
  logic             w0_ok;
  logic             w1_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      INIT: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1)) state_nx = RUN;
      end
      RUN:     state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  assign run   = (state == RUN);
  assign ready = run;
  assign w0_ok = run & we0 & ~((ZERO_REG != 0) && (wa0 == '0));
  assign w1_ok = run & we1 & ~((ZERO_REG != 0) && (wa1 == '0));

  // Port 1 is written after port 0 so it wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else begin
        if (w0_ok) mem[wa0] <= wd0;
        if (w1_ok) mem[wa1] <= wd1;
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (run) begin
        rd[k*WIDTH +: WIDTH] = mem[ra[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (w0_ok && (wa0 == ra[k*AW +: AW])) rd[k*WIDTH +: WIDTH] = wd0;
        if (w1_ok && (wa1 == ra[k*AW +: AW])) rd[k*WIDTH +: WIDTH] = wd1;
`endif
        if ((ZERO_REG != 0) && (ra[k*AW +: AW] == '0)) rd[k*WIDTH +: WIDTH] = '0;
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .iss      (iss),
    .iss_addr (iss_addr),
    .clr      (we1),
    .clr_addr (wa1),
    .ra       (ra),
    .rbusy    (rbusy)
  );

endmodule
